// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32 fetch constants and the IF/ID record type
package riscv_pkg;
    localparam int XLEN = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            valid;
    } if_id_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with hold and flush-to-bubble
module if_id_reg import riscv_pkg::*; #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            hold,
    input  logic            flush,
    input  logic [XLEN-1:0] d_pc,
    input  logic [XLEN-1:0] d_instr,
    output logic [XLEN-1:0] q_pc,
    output logic [XLEN-1:0] q_instr,
    output logic            q_valid
);
    if_id_t q;
    // flush beats hold; a flushed stage holds a NOP bubble at pc 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
        else if (flush) q <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
        else if (!hold) q <= '{pc: d_pc, instr: d_instr, valid: 1'b1};
    end
    assign q_pc = q.pc;
    assign q_instr = q.instr;
    assign q_valid = q.valid;
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC register, next-PC mux, IF/ID register and redirect counter
module pc_fetch_ctrl import riscv_pkg::*; #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_address,
    input  logic [XLEN-1:0] instr_rdata,
    output logic [XLEN-1:0] instr_addr,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr,
    output logic            if_id_valid,
    output logic [15:0]     flush_count
);
    logic [XLEN-1:0] pc, pc_plus4, next_pc;
    assign pc_plus4 = pc + XLEN'(INSTR_BYTES);
    // single mux: redirect (low bits dropped) over hold over sequential advance
    always_comb next_pc = branch_taken ? (branch_address & ~XLEN'(3)) : stall ? pc : pc_plus4;
    // PC register, driven straight to instruction memory
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc <= RESET_PC;
        else pc <= next_pc;
    end
    // count redirects, sticking at all-ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset) flush_count <= '0;
        else if (branch_taken && flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
    end
    assign instr_addr = pc;
    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk(clk),
        .reset(reset),
        .hold(stall),
        .flush(branch_taken),
        .d_pc(pc),
        .d_instr(instr_rdata),
        .q_pc(if_id_pc),
        .q_instr(if_id_instr),
        .q_valid(if_id_valid)
    );
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed and random checks against a behavioural fetch model
module tb_pc_fetch_ctrl;
    logic        clk = 1'b0, reset = 1'b1, stall = 1'b0, branch_taken = 1'b0;
    logic [31:0] branch_address = '0, instr_rdata = '0;
    logic [31:0] instr_addr, if_id_pc, if_id_instr;
    logic        if_id_valid;
    logic [15:0] flush_count;
    logic [31:0] w_addr, w_pc, w_instr, w_rdata = '0;
    logic        w_valid;
    logic [15:0] w_count;
    int errors = 0, checks = 0;
    logic [31:0] m_pc, m_ipc, m_iinstr;
    logic        m_valid;
    int          m_fc;

    pc_fetch_ctrl dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_address(branch_address), .instr_rdata(instr_rdata),
        .instr_addr(instr_addr), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
        .if_id_valid(if_id_valid), .flush_count(flush_count)
    );

    pc_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .reset(reset), .stall(1'b0), .branch_taken(1'b0),
        .branch_address(32'h0), .instr_rdata(w_rdata),
        .instr_addr(w_addr), .if_id_pc(w_pc), .if_id_instr(w_instr),
        .if_id_valid(w_valid), .flush_count(w_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ipc = 32'h0; m_iinstr = 32'h13; m_valid = 1'b0; m_fc = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".addr"}, instr_addr, m_pc);
        check({tag, ".ipc"}, if_id_pc, m_ipc);
        check({tag, ".instr"}, if_id_instr, m_iinstr);
        check({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, m_valid});
        check({tag, ".fc"}, {16'b0, flush_count}, m_fc[31:0]);
    endtask

    task automatic step();
        logic r, b, s;
        logic [31:0] ba, rd;
        r = reset; b = branch_taken; s = stall; ba = branch_address; rd = instr_rdata;
        @(posedge clk);
        #1;
        if (r) model_reset();
        else if (b) begin
            m_pc = ba - (ba % 4);
            m_ipc = 0; m_iinstr = 32'h13; m_valid = 0;
            if (m_fc < 65535) m_fc++;
        end else if (!s) begin
            m_ipc = m_pc; m_iinstr = rd; m_valid = 1;
            m_pc = m_pc + 4;
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        model_reset();
        check_all("rst_hold");
        reset = 1'b0;
        check("wrap0", w_addr, 32'hFFFF_FFF8);
        instr_rdata = 32'hA0; step(); check_all("seq0"); check("wrap1", w_addr, 32'hFFFF_FFFC);
        instr_rdata = 32'hA1; step(); check_all("seq1"); check("wrap2", w_addr, 32'h0000_0000);
        instr_rdata = 32'hA2; step(); check_all("seq2");
        check("seq_addr", instr_addr, 32'd12);
        check("seq_ipc", if_id_pc, 32'd8);
        instr_rdata = 32'hA3; step(); check_all("seq3");
        branch_taken = 1'b1; branch_address = 32'd24; step(); check_all("br");
        check("br_addr", instr_addr, 32'd24);
        check("br_fc", {16'b0, flush_count}, 32'd1);
        branch_taken = 1'b0; instr_rdata = 32'hB0; step(); check_all("br_next");
        check("br_ipc", if_id_pc, 32'd24);
        branch_taken = 1'b1; branch_address = 32'd4; step(); check_all("br4");
        branch_taken = 1'b0; instr_rdata = 32'hC0; step(); check_all("adv8");
        stall = 1'b1; instr_rdata = 32'hDEAD;
        step(); check_all("stall0");
        step(); check_all("stall1");
        check("stall_addr", instr_addr, 32'd8);
        check("stall_ipc", if_id_pc, 32'd4);
        branch_taken = 1'b1; branch_address = 32'h103; step(); check_all("stall_br");
        check("stall_br_addr", instr_addr, 32'h100);
        // asynchronous reset mid-cycle while stall and branch are requested
        #3 reset = 1'b1;
        #1 model_reset();
        check_all("async_rst");
        step(); check_all("rst_edge");
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; instr_rdata = 32'h77;
        step(); check_all("post_rst");
        for (int i = 0; i < 2000; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 7) == 0);
            branch_address = $urandom;
            instr_rdata = $urandom;
            reset = ($urandom_range(0, 199) == 0);
            step();
            check_all("rand");
            reset = 1'b0;
        end
        branch_taken = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            branch_address = $urandom;
            step();
        end
        check_all("sat");
        check("sat_fc", {16'b0, flush_count}, 32'h0000_FFFF);
        step(); check_all("sat_more");
        branch_taken = 1'b0; instr_rdata = 32'h55; step(); check_all("sat_adv");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013: encoding of addi x0,x0,0 injected on flush/reset.
REQ-003 SHALL have port clk  input  1: single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1: reset is asynchronous and active-high.
REQ-005 SHALL have port stall  input  1: hazard-unit request to hold PC and IF/ID.
REQ-006 SHALL have port branch_taken  input  1: EX-stage redirect request.
REQ-007 SHALL have port branch_address  input  32: redirect target from the EX branch PC adder.
REQ-008 SHALL have port instr_rdata  input  32: combinational instruction-memory read data for instr_addr.
REQ-009 SHALL have port instr_addr  output  32: current PC, driven to instruction memory.
REQ-010 SHALL have port if_id_pc  output  32: PC of instruction held in IF/ID.
REQ-011 SHALL have port if_id_instr  output  32: instruction held in IF/ID.
REQ-012 SHALL have port if_id_valid  output  1: IF/ID holds a real instruction.
REQ-013 SHALL have port flush_count  output  16: saturating count of redirects taken.

Function
REQ-014 instr_addr SHALL equal the PC register directly (no combinational path from inputs).
REQ-015 Priority per edge: branch_taken > stall > normal advance.
REQ-016 branch_taken=1: PC <= {branch_address[31:2],2'b00}; if_id_instr <= NOP_INSTR; if_id_valid <= 0; if_id_pc <= 0; flush_count increments.
REQ-017 branch_taken=0, stall=1: PC, if_id_pc, if_id_instr, if_id_valid SHALL all hold.
REQ-018 Normal advance: PC <= PC + 4; if_id_pc <= PC; if_id_instr <= instr_rdata; if_id_valid <= 1.
REQ-019 PC+4 SHALL be 32-bit modulo: 32'hFFFF_FFFC advances to 32'h0000_0000, no flag.
REQ-020 branch_address[1:0] SHALL be ignored (forced to 00); no misalignment exception.
REQ-021 flush_count SHALL saturate at 16'hFFFF and not wrap.
REQ-022 branch_taken with stall=1 SHALL still redirect and flush (stall is overridden).
REQ-023 Latency: redirect visible on instr_addr one cycle after the branch_taken edge; fetched instruction appears in IF/ID one cycle after its address is on instr_addr.
REQ-024 Back-to-back branch_taken cycles SHALL each redirect and count; IF/ID stays invalid throughout.

Reset
REQ-025 On reset assertion, asynchronously: PC=RESET_PC, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0, flush_count=0.
REQ-026 While reset=1, all inputs SHALL be ignored; first advance occurs on the first rising edge with reset=0.
REQ-027 Reset mid-operation (including during stall or branch) SHALL discard all state and return to REQ-025 values.

Structure
REQ-028 Shared package riscv_pkg SHALL hold XLEN=32, INSTR_BYTES=4, NOP_INSTR constant and the IF/ID record type {pc, instr, valid}.
REQ-029 IF/ID pipeline register SHALL be a sub-module if_id_reg (ports: clk, reset, hold, flush, d_pc, d_instr, q_pc, q_instr, q_valid); PC register and next-PC mux stay in pc_fetch_ctrl.
REQ-030 Next-PC logic SHALL be a single mux (branch / hold / +4); no second adder beyond PC+4.

Verification
REQ-031 Reset: assert reset mid-cycle -> instr_addr=0, if_id_valid=0, if_id_instr=0x00000013, flush_count=0 immediately (before clock edge).
REQ-032 Sequential fetch: release reset, instr_rdata=0xA0,0xA1,0xA2 -> instr_addr 0,4,8,12; IF/ID (0,0xA0),(4,0xA1),(8,0xA2) valid=1.
REQ-033 Branch: at PC=16, branch_taken=1, branch_address=24 (16+8) -> next instr_addr=24, if_id_valid=0, if_id_instr=0x13, flush_count=1; following cycle if_id_pc=24.
REQ-034 Stall vs branch: stall=1 two cycles at PC=8 -> instr_addr held at 8, IF/ID unchanged; then stall=1 with branch_taken=1, branch_address=0x103 -> instr_addr=0x100, flush applied.
REQ-035 Wrap: RESET_PC=32'hFFFF_FFF8 -> instr_addr FFFFFFF8, FFFFFFFC, 00000000.
REQ-036 Saturation: force 65,540 branch_taken cycles -> flush_count stops at 0xFFFF.
